// File: rtl/corners_pkg.sv
// Shared types for the corners extreme-point detector.
package corners_pkg;

  localparam int unsigned COORD_W = 16;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x;
    coord_t y;
  } point_t;

endpackage

// File: rtl/corners_if.sv
// Pixel stream and extreme-point result bundle between the binariser and the detector.
interface corners_if;
  import corners_pkg::*;

  coord_t width;
  coord_t height;
  logic   in_write;
  logic   in_pixel;
  logic   out_write;
  logic   out_pixel;
  coord_t out_left_x;
  coord_t out_left_y;
  coord_t out_top_x;
  coord_t out_top_y;
  coord_t out_right_x;
  coord_t out_right_y;
  coord_t out_bottom_x;
  coord_t out_bottom_y;

  modport master (
    output width, height, in_write, in_pixel,
    input  out_write, out_pixel,
    input  out_left_x, out_left_y, out_top_x, out_top_y,
    input  out_right_x, out_right_y, out_bottom_x, out_bottom_y
  );

  modport slave (
    input  width, height, in_write, in_pixel,
    output out_write, out_pixel,
    output out_left_x, out_left_y, out_top_x, out_top_y,
    output out_right_x, out_right_y, out_bottom_x, out_bottom_y
  );

endinterface

// File: rtl/corners_raster_counter.sv
// Raster-order x/y position of the pixel currently offered, plus a last-pixel-of-frame flag.
module corners_raster_counter
  import corners_pkg::*;
(
  input  logic   clock,
  input  logic   reset_n,
  input  logic   in_write,
  input  coord_t width,
  input  coord_t height,
  output coord_t x,
  output coord_t y,
  output logic   frame_end
);

  coord_t x_q, x_d;
  coord_t y_q, y_d;
  logic   x_last, y_last;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned, which would infer a latch.
  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    x_last    = (x_q == coord_t'(width - 1'b1));
    y_last    = (y_q == coord_t'(height - 1'b1));
    frame_end = in_write && x_last && y_last;
    if (in_write) begin
      if (x_last) begin
        x_d = '0;
        y_d = y_last ? '0 : coord_t'(y_q + 1'b1);
      end else begin
        x_d = coord_t'(x_q + 1'b1);
      end
    end
  end

  // NOTE: state updates use non-blocking assignments so all flops sample the same pre-edge values.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      x_q <= '0;
      y_q <= '0;
    end else begin
      x_q <= x_d;
      y_q <= y_d;
    end
  end

  assign x = x_q;
  assign y = y_q;

endmodule

// File: rtl/corners.sv
// Streaming extreme-point detector: forwards pixels with one cycle delay and publishes the
// leftmost/topmost/rightmost/bottommost white pixel of each frame after its last pixel.
module corners
  import corners_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  corners_if.slave bus
);

  coord_t cur_x, cur_y;
  logic   frame_end;
  point_t cur;
  logic   hit;

  point_t left_q, left_d, top_q, top_d, right_q, right_d, bottom_q, bottom_d;
  point_t nxt_left, nxt_top, nxt_right, nxt_bottom;
  logic   found_q, found_d, nxt_found;
  point_t out_left_q, out_left_d, out_top_q, out_top_d;
  point_t out_right_q, out_right_d, out_bottom_q, out_bottom_d;
  logic   write_q, write_d, pixel_q, pixel_d;

  corners_raster_counter u_counter (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_write  (bus.in_write),
    .width     (bus.width),
    .height    (bus.height),
    .x         (cur_x),
    .y         (cur_y),
    .frame_end (frame_end)
  );

  always_comb begin
    cur        = '{x: cur_x, y: cur_y};
    hit        = bus.in_write && bus.in_pixel;
    write_d    = bus.in_write;
    pixel_d    = bus.in_pixel;
    nxt_left   = left_q;
    nxt_top    = top_q;
    nxt_right  = right_q;
    nxt_bottom = bottom_q;
    nxt_found  = found_q;

    if (hit) begin
      if (!found_q) begin
        nxt_left   = cur;
        nxt_top    = cur;
        nxt_right  = cur;
        nxt_bottom = cur;
        nxt_found  = 1'b1;
      end else begin
        // Strict compares keep the earliest pixel in raster order on ties.
        if (cur.x < left_q.x)   nxt_left   = cur;
        if (cur.x > right_q.x)  nxt_right  = cur;
        if (cur.y > bottom_q.y) nxt_bottom = cur;
      end
    end

    left_d       = nxt_left;
    top_d        = nxt_top;
    right_d      = nxt_right;
    bottom_d     = nxt_bottom;
    found_d      = nxt_found;
    out_left_d   = out_left_q;
    out_top_d    = out_top_q;
    out_right_d  = out_right_q;
    out_bottom_d = out_bottom_q;

    // The last pixel's own update is folded in before publishing.
    if (frame_end) begin
      out_left_d   = nxt_found ? nxt_left   : '0;
      out_top_d    = nxt_found ? nxt_top    : '0;
      out_right_d  = nxt_found ? nxt_right  : '0;
      out_bottom_d = nxt_found ? nxt_bottom : '0;
      left_d       = '0;
      top_d        = '0;
      right_d      = '0;
      bottom_d     = '0;
      found_d      = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      left_q       <= '0;
      top_q        <= '0;
      right_q      <= '0;
      bottom_q     <= '0;
      found_q      <= 1'b0;
      out_left_q   <= '0;
      out_top_q    <= '0;
      out_right_q  <= '0;
      out_bottom_q <= '0;
      write_q      <= 1'b0;
      pixel_q      <= 1'b0;
    end else begin
      left_q       <= left_d;
      top_q        <= top_d;
      right_q      <= right_d;
      bottom_q     <= bottom_d;
      found_q      <= found_d;
      out_left_q   <= out_left_d;
      out_top_q    <= out_top_d;
      out_right_q  <= out_right_d;
      out_bottom_q <= out_bottom_d;
      write_q      <= write_d;
      pixel_q      <= pixel_d;
    end
  end

  assign bus.out_write    = write_q;
  assign bus.out_pixel    = pixel_q;
  assign bus.out_left_x   = out_left_q.x;
  assign bus.out_left_y   = out_left_q.y;
  assign bus.out_top_x    = out_top_q.x;
  assign bus.out_top_y    = out_top_q.y;
  assign bus.out_right_x  = out_right_q.x;
  assign bus.out_right_y  = out_right_q.y;
  assign bus.out_bottom_x = out_bottom_q.x;
  assign bus.out_bottom_y = out_bottom_q.y;

endmodule

// File: tb/tb_corners.sv
// Bench for corners: directed frames plus randomized frames checked against an extreme-point model.
module tb_corners;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  int   n_compared = 0;
  int   n_mismatched = 0;

  bit   pix_mem [0:76799];
  int   cur_w, cur_h;

  corners_if bus ();

  corners dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  function automatic logic [127:0] read_outs();
    return {bus.out_left_x, bus.out_left_y, bus.out_top_x, bus.out_top_y,
            bus.out_right_x, bus.out_right_y, bus.out_bottom_x, bus.out_bottom_y};
  endfunction

  function automatic logic [127:0] pack8(int lx, int ly, int tx, int ty, int rx, int ry, int bx, int by);
    return {16'(lx), 16'(ly), 16'(tx), 16'(ty), 16'(rx), 16'(ry), 16'(bx), 16'(by)};
  endfunction

  // Extremes from their definitions: min/max over the white set, ties broken by the secondary key.
  function automatic logic [127:0] model(int w, int h);
    int min_x = w, max_x = -1, min_y = h, max_y = -1;
    int ly = -1, tx = -1, ry = -1, bx = -1;
    for (int y = 0; y < h; y++)
      for (int x = 0; x < w; x++)
        if (pix_mem[y*w+x]) begin
          if (x < min_x) min_x = x;
          if (x > max_x) max_x = x;
          if (y < min_y) min_y = y;
          if (y > max_y) max_y = y;
        end
    if (max_x < 0) return '0;
    for (int y = h - 1; y >= 0; y--) begin
      if (pix_mem[y*w+min_x]) ly = y;
      if (pix_mem[y*w+max_x]) ry = y;
    end
    for (int x = w - 1; x >= 0; x--) begin
      if (pix_mem[min_y*w+x]) tx = x;
      if (pix_mem[max_y*w+x]) bx = x;
    end
    return pack8(min_x, ly, tx, min_y, max_x, ry, bx, max_y);
  endfunction

  task automatic set_frame(int w, int h);
    cur_w = w;
    cur_h = h;
    bus.width  = 16'(w);
    bus.height = 16'(h);
    for (int i = 0; i < w * h; i++) pix_mem[i] = 1'b0;
  endtask

  task automatic send(bit p);
    bus.in_write = 1'b1;
    bus.in_pixel = p;
    @(posedge clock);
    #1;
    bus.in_write = 1'b0;
    bus.in_pixel = 1'b0;
  endtask

  task automatic play(int first, int count, int max_gap);
    for (int i = first; i < first + count; i++) begin
      repeat ($urandom_range(max_gap, 0)) begin
        @(posedge clock);
        #1;
      end
      send(pix_mem[i]);
    end
  endtask

  task automatic apply_reset();
    reset_n      = 1'b0;
    bus.in_write = 1'b1;
    bus.in_pixel = 1'b1;
    @(posedge clock);
    #1;
    reset_n      = 1'b1;
    bus.in_write = 1'b0;
    bus.in_pixel = 1'b0;
  endtask

  task automatic test_reset();
    logic [129:0] got;
    apply_reset();
    got = {read_outs(), bus.out_write, bus.out_pixel};
    n_compared++;
    if (got !== '0) begin
      n_mismatched++;
      $display("FAIL reset_state got=%h exp=0", got);
    end
  endtask

  task automatic test_alternating();
    logic [127:0] exp = pack8(1, 0, 1, 0, 319, 0, 1, 239);
    int pt_bad = 0;
    set_frame(320, 240);
    for (int i = 0; i < 76800; i++) begin
      if (i == 76799) begin
        n_compared++;
        if (read_outs() !== '0) begin
          n_mismatched++;
          $display("FAIL alt_early_publish got=%h exp=0", read_outs());
        end
      end
      bus.in_write = 1'b1;
      bus.in_pixel = i[0];
      @(posedge clock);
      #1;
      n_compared++;
      if (bus.out_pixel !== i[0] || bus.out_write !== 1'b1) begin
        n_mismatched++;
        if (pt_bad < 5)
          $display("FAIL alt_passthrough idx=%0d got w=%b p=%b exp w=1 p=%b",
                   i, bus.out_write, bus.out_pixel, i[0]);
        pt_bad++;
      end
    end
    bus.in_write = 1'b0;
    bus.in_pixel = 1'b0;
    n_compared++;
    if (read_outs() !== exp) begin
      n_mismatched++;
      $display("FAIL alt_corners got=%h exp=%h", read_outs(), exp);
    end
  endtask

  task automatic test_single_then_black();
    logic [127:0] exp = pack8(5, 2, 5, 2, 5, 2, 5, 2);
    set_frame(8, 4);
    pix_mem[2*8+5] = 1'b1;
    play(0, 32, 0);
    n_compared++;
    if (read_outs() !== exp) begin
      n_mismatched++;
      $display("FAIL single_pixel got=%h exp=%h", read_outs(), exp);
    end
    set_frame(8, 4);
    play(0, 32, 1);
    n_compared++;
    if (read_outs() !== '0) begin
      n_mismatched++;
      $display("FAIL all_black got=%h exp=0", read_outs());
    end
  endtask

  task automatic test_diamond();
    logic [127:0] exp = pack8(1, 3, 3, 1, 6, 3, 4, 6);
    set_frame(8, 8);
    pix_mem[1*8+3] = 1'b1;
    pix_mem[3*8+1] = 1'b1;
    pix_mem[3*8+6] = 1'b1;
    pix_mem[6*8+4] = 1'b1;
    play(0, 64, 5);
    n_compared++;
    if (read_outs() !== exp) begin
      n_mismatched++;
      $display("FAIL diamond_gaps got=%h exp=%h", read_outs(), exp);
    end
  endtask

  task automatic test_mid_reset();
    logic [127:0] exp = pack8(0, 3, 3, 0, 3, 0, 0, 3);
    set_frame(4, 4);
    for (int i = 0; i < 10; i++) pix_mem[i] = 1'b1;
    play(0, 10, 0);
    apply_reset();
    n_compared++;
    if (read_outs() !== '0) begin
      n_mismatched++;
      $display("FAIL mid_reset_clear got=%h exp=0", read_outs());
    end
    set_frame(4, 4);
    pix_mem[3*4+0] = 1'b1;
    pix_mem[0*4+3] = 1'b1;
    play(0, 16, 0);
    n_compared++;
    if (read_outs() !== exp) begin
      n_mismatched++;
      $display("FAIL mid_reset_frame got=%h exp=%h", read_outs(), exp);
    end
  endtask

  task automatic test_back_to_back();
    logic [127:0] prev = read_outs();
    logic [127:0] exp_a, exp_b;
    set_frame(4, 3);
    for (int i = 0; i < 12; i++) pix_mem[i] = 1'($urandom_range(1, 0));
    pix_mem[0] = 1'b1;
    exp_a = model(4, 3);
    play(0, 11, 0);
    n_compared++;
    if (read_outs() !== prev) begin
      n_mismatched++;
      $display("FAIL b2b_a_early got=%h exp=%h", read_outs(), prev);
    end
    play(11, 1, 0);
    n_compared++;
    if (read_outs() !== exp_a) begin
      n_mismatched++;
      $display("FAIL b2b_a_result got=%h exp=%h", read_outs(), exp_a);
    end
    set_frame(4, 3);
    for (int i = 0; i < 12; i++) pix_mem[i] = 1'($urandom_range(1, 0));
    pix_mem[0]  = 1'b0;
    pix_mem[6]  = 1'b1;
    pix_mem[11] = 1'b0;
    exp_b = model(4, 3);
    play(0, 11, 0);
    n_compared++;
    if (read_outs() !== exp_a) begin
      n_mismatched++;
      $display("FAIL b2b_b_early got=%h exp=%h", read_outs(), exp_a);
    end
    play(11, 1, 0);
    n_compared++;
    if (read_outs() !== exp_b) begin
      n_mismatched++;
      $display("FAIL b2b_b_result got=%h exp=%h", read_outs(), exp_b);
    end
  endtask

  task automatic test_random();
    logic [127:0] exp;
    int w, h, density;
    for (int k = 0; k < 24; k++) begin
      w = (k == 0 || k == 2) ? 1 : int'($urandom_range(9, 1));
      h = (k == 1 || k == 2) ? 1 : int'($urandom_range(9, 1));
      density = int'($urandom_range(60, 3));
      set_frame(w, h);
      for (int i = 0; i < w * h; i++) pix_mem[i] = ($urandom_range(99, 0) < density);
      exp = model(w, h);
      play(0, w * h, 2);
      n_compared++;
      if (read_outs() !== exp) begin
        n_mismatched++;
        $display("FAIL random_frame k=%0d w=%0d h=%0d got=%h exp=%h", k, w, h, read_outs(), exp);
      end
    end
  endtask

  initial begin
    bus.width    = 16'd1;
    bus.height   = 16'd1;
    bus.in_write = 1'b0;
    bus.in_pixel = 1'b0;
    test_reset();
    test_alternating();
    test_single_then_black();
    test_diamond();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
